mc_control_unit: RTL
====================

Name: mc_control_unit

Overview:
- Multicycle successor to the single-cycle control unit.
- An FSM sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and stalls on instruction and data memory handshakes.
- A memory-wait watchdog converts a hung memory into a halt.
- It sits between the caches and the datapath, drives all datapath selects, and generalises the datapath word and register-address widths.

Parameters:
- WORD_W, 32, datapath/instruction word width; only the low 32 bits of imemload are decoded.
- REG_AW, 5, register-select width.
- WAIT_MAX, 255, maximum consecutive stall cycles in one memory state before mem_err; legal range 1..2^16-1.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- imemload  in  WORD_W  instruction from icache, valid when ihit=1
- ihit  in  1  instruction fetch complete
- dhit  in  1  data access complete
- z_fl  in  1  ALU zero flag, valid in EXECUTE
- iREN  out  1  instruction read request
- dREN  out  1  data read request
- dWEN  out  1  data write request
- datomic  out  1  atomic (LL/SC) access qualifier
- ir_en  out  1  load instruction register
- pc_en  out  1  update PC
- pc_select  out  2  NEXT/BRANCH/JUMP/JUMPREGISTER
- aluop  out  4  aluop_t
- alusrc  out  1  1 = immediate, 0 = rdat2
- imm_sel  out  2  SIGN/ZERO/SHAMT extension select
- wdatsel  out  2  PORT_O/DMEMLOAD/LUI_WORD/RTN_ADDR
- WEN  out  1  register-file write enable
- wsel  out  REG_AW  destination register
- cpu_halt  out  1  sticky halt
- mem_err  out  1  sticky watchdog error

Behaviour:
- Reset (nRST=0, asynchronous): state=FETCH, IR=0, wait_cnt=0, cpu_halt=0, mem_err=0. All request, enable and WEN outputs are 0; selects take their defaults (NEXT, ALU_ADD, PORT_O, wsel=0). Mid-access reset abandons the access; no write is issued.
- Outputs are Moore-decoded from state plus the latched IR. Exception: pc_select in EXECUTE depends on z_fl.
- FETCH: iREN=1.
  - On ihit: ir_en=1, pc_en=1 (pc_select=NEXT), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: register operands read; one cycle; go to EXECUTE.
  - HALT opcode goes to HALTED instead.
  - Unknown opcode or funct goes back to FETCH with no side effects.
- EXECUTE: aluop/alusrc/imm_sel follow the standard decode: SIGN for arithmetic/LW/SW, ZERO for ANDI/ORI/XORI, SHAMT for SLL/SRL, SUB for BEQ/BNE.
  - BEQ with z_fl=1, BNE with z_fl=0: pc_en=1, pc_select=BRANCH, then FETCH.
  - J: pc_en=1, pc_select=JUMP, then FETCH.
  - JAL: pc_en=1, pc_select=JUMP, WEN=1, wsel=31, wdatsel=RTN_ADDR, then FETCH.
  - JR: pc_en=1, pc_select=JUMPREGISTER, then FETCH.
  - LW/SW go to MEMORY. All other instructions go to WRITEBACK.
- MEMORY: dREN (LW) or dWEN (SW) held high until dhit.
  - On dhit: LW goes to WRITEBACK, SW goes to FETCH.
- WRITEBACK: exactly one cycle with WEN=1, then FETCH.
  - wsel = rd for R-type, rt otherwise.
  - wdatsel: DMEMLOAD for LW, LUI_WORD for LUI, PORT_O otherwise.
- HALTED: absorbing state. cpu_halt=1, all requests 0. Only nRST exits.
- Watchdog:
  - wait_cnt increments each cycle in FETCH without ihit or in MEMORY without dhit.
  - It clears on a hit and on every state change.
  - When wait_cnt would reach WAIT_MAX: mem_err=1, go to HALTED, requests dropped the same cycle.
  - The counter saturates and never wraps.
- Invariants:
  - WEN is never asserted outside WRITEBACK, except JAL in EXECUTE.
  - iREN, dREN and dWEN are mutually exclusive.
  - pc_en is at most once per instruction after fetch.
- Latency with zero-wait memory:
  - ALU ops: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branches and jumps: 3 cycles.

Optional Feature:
- Macro: MC_ATOMIC_EN.
- With the macro: LL and SC are decoded.
  - LL behaves like LW with datomic=1 in MEMORY.
  - SC uses MEMORY with dWEN=1 and datomic=1, then goes to WRITEBACK (wsel=rt, wdatsel=DMEMLOAD). This writes the success flag returned by the cache.
- Without the macro: datomic is tied 0, and LL/SC are treated as unknown opcodes (NOP back to FETCH).

Decomposition:
- cpu_types_pkg gains mc_state_t (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED) and imm_sel_t (SIGN, ZERO, SHAMT).
- cpu_types_pkg reuses the existing opcode_t, funct_t, aluop_t, pc_select and wdatsel enumerations.
- Sub-module mc_decode: purely combinational IR-to-control-class decoder. Outputs are is_mem, is_load, is_branch, is_jump, writes_reg, aluop, imm_sel and wsel. The FSM in mc_control_unit gates these outputs by state.

Test Plan:
- ADDI $1,$0,5 with ihit=1 constantly -> FETCH→DECODE→EXECUTE(aluop=ADD, alusrc=1, imm_sel=SIGN)→WRITEBACK(WEN=1, wsel=1) → 4 cycles, one WEN pulse.
- LW $2,4($1) with dhit delayed 3 cycles -> dREN high exactly 4 MEMORY cycles; WRITEBACK WEN=1, wdatsel=DMEMLOAD, wsel=2; total 8 cycles.
- BEQ with z_fl=1, then BNE with z_fl=1 -> first gives pc_en=1, pc_select=BRANCH in EXECUTE; second gives no pc_en in EXECUTE; both return to FETCH with no WEN.
- JAL 0x40 -> EXECUTE asserts WEN=1, wsel=31, wdatsel=RTN_ADDR, pc_select=JUMP in the same cycle.
- WAIT_MAX=4 with ihit held 0 -> mem_err=1 and cpu_halt=1 after the 4th stall cycle, iREN=0 thereafter. Pulsing nRST low clears both and restarts FETCH.
- With MC_ATOMIC_EN defined, SC with dhit after 1 cycle -> dWEN=1 and datomic=1 for 2 cycles, then WRITEBACK WEN=1. Without the macro, the same SC produces no dWEN and returns to FETCH after DECODE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared MIPS control enumerations for the multicycle control unit and its decoder.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000, J     = 6'b000010, JAL   = 6'b000011,
        BEQ   = 6'b000100, BNE   = 6'b000101, ADDI  = 6'b001000,
        ADDIU = 6'b001001, SLTI  = 6'b001010, SLTIU = 6'b001011,
        ANDI  = 6'b001100, ORI   = 6'b001101, XORI  = 6'b001110,
        LUI   = 6'b001111, LW    = 6'b100011, SW    = 6'b101011,
        LL    = 6'b110000, SC    = 6'b111000, HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'b000000, SRL  = 6'b000010, JR   = 6'b001000,
        ADD  = 6'b100000, ADDU = 6'b100001, SUB  = 6'b100010,
        SUBU = 6'b100011, AND  = 6'b100100, OR   = 6'b100101,
        XOR  = 6'b100110, NOR  = 6'b100111, SLT  = 6'b101010,
        SLTU = 6'b101011
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL = 4'b0000, ALU_SRL = 4'b0001, ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011, ALU_AND = 4'b0100, ALU_OR  = 4'b0101,
        ALU_XOR = 4'b0110, ALU_NOR = 4'b0111, ALU_SLT = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;

    typedef enum logic [1:0] {NEXT, BRANCH, JUMP, JUMPREGISTER} pc_select_t;
    typedef enum logic [1:0] {PORT_O, DMEMLOAD, LUI_WORD, RTN_ADDR} wdatsel_t;
    typedef enum logic [1:0] {SIGN, ZERO, SHAMT} imm_sel_t;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED
    } mc_state_t;

    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/mc_decode.sv
// Combinational IR-to-control-class decoder; the FSM gates these by state.
// LL/SC decode only when MC_ATOMIC_EN is defined.
module mc_decode
    import cpu_types_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       ir,
    output logic              valid,
    output logic              is_halt,
    output logic              is_mem,
    output logic              is_load,
    output logic              is_atomic,
    output logic              is_branch,
    output logic              is_bne,
    output logic              is_jump,
    output logic              is_link,
    output logic              writes_reg,
    output logic              alusrc,
    output aluop_t            aluop,
    output imm_sel_t          imm_sel,
    output pc_select_t        jump_sel,
    output wdatsel_t          wdatsel,
    output logic [REG_AW-1:0] wsel
);

    logic unused_fields;
    assign unused_fields = ^{ir[25:21], ir[10:6]};

    always_comb begin
        valid = 1'b1;      is_halt = 1'b0;   is_mem = 1'b0;    is_load = 1'b0;
        is_atomic = 1'b0;  is_branch = 1'b0; is_bne = 1'b0;    is_jump = 1'b0;
        is_link = 1'b0;    writes_reg = 1'b0;
        alusrc = 1'b1;     aluop = ALU_ADD;  imm_sel = SIGN;
        jump_sel = NEXT;   wdatsel = PORT_O; wsel = REG_AW'(ir[20:16]);
        case (ir[31:26])
            RTYPE: begin
                alusrc = 1'b0;
                writes_reg = 1'b1;
                wsel = REG_AW'(ir[15:11]);
                case (ir[5:0])
                    SLL:       begin aluop = ALU_SLL; alusrc = 1'b1; imm_sel = SHAMT; end
                    SRL:       begin aluop = ALU_SRL; alusrc = 1'b1; imm_sel = SHAMT; end
                    JR:        begin writes_reg = 1'b0; is_jump = 1'b1; jump_sel = JUMPREGISTER; end
                    ADD, ADDU: aluop = ALU_ADD;
                    SUB, SUBU: aluop = ALU_SUB;
                    AND:       aluop = ALU_AND;
                    OR:        aluop = ALU_OR;
                    XOR:       aluop = ALU_XOR;
                    NOR:       aluop = ALU_NOR;
                    SLT:       aluop = ALU_SLT;
                    SLTU:      aluop = ALU_SLTU;
                    default:   begin valid = 1'b0; writes_reg = 1'b0; end
                endcase
            end
            ADDI, ADDIU: writes_reg = 1'b1;
            SLTI:  begin aluop = ALU_SLT;  writes_reg = 1'b1; end
            SLTIU: begin aluop = ALU_SLTU; writes_reg = 1'b1; end
            ANDI:  begin aluop = ALU_AND;  imm_sel = ZERO; writes_reg = 1'b1; end
            ORI:   begin aluop = ALU_OR;   imm_sel = ZERO; writes_reg = 1'b1; end
            XORI:  begin aluop = ALU_XOR;  imm_sel = ZERO; writes_reg = 1'b1; end
            LUI:   begin writes_reg = 1'b1; wdatsel = LUI_WORD; end
            LW:    begin is_mem = 1'b1; is_load = 1'b1; writes_reg = 1'b1; wdatsel = DMEMLOAD; end
            SW:    is_mem = 1'b1;
            BEQ:   begin is_branch = 1'b1; aluop = ALU_SUB; alusrc = 1'b0; end
            BNE:   begin is_branch = 1'b1; is_bne = 1'b1; aluop = ALU_SUB; alusrc = 1'b0; end
            J:     begin is_jump = 1'b1; jump_sel = JUMP; alusrc = 1'b0; end
            JAL: begin
                is_jump = 1'b1; is_link = 1'b1; jump_sel = JUMP; alusrc = 1'b0;
                wdatsel = RTN_ADDR; wsel = REG_AW'(31);
            end
            HALT:  is_halt = 1'b1;
`ifdef MC_ATOMIC_EN
            LL: begin
                is_mem = 1'b1; is_load = 1'b1; is_atomic = 1'b1;
                writes_reg = 1'b1; wdatsel = DMEMLOAD;
            end
            // SC writes back the success flag the cache returns on dmemload
            SC: begin
                is_mem = 1'b1; is_atomic = 1'b1;
                writes_reg = 1'b1; wdatsel = DMEMLOAD;
            end
`endif
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with memory-wait watchdog.
// Define MC_ATOMIC_EN to enable LL/SC (datomic); otherwise datomic stays 0.
module mc_control_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int REG_AW   = 5,
    parameter int WAIT_MAX = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] imemload,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              z_fl,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              datomic,
    output logic              ir_en,
    output logic              pc_en,
    output pc_select_t        pc_select,
    output aluop_t            aluop,
    output logic              alusrc,
    output imm_sel_t          imm_sel,
    output wdatsel_t          wdatsel,
    output logic              WEN,
    output logic [REG_AW-1:0] wsel,
    output logic              cpu_halt,
    output logic              mem_err
);

    mc_state_t             state_q, state_d;
    logic [31:0]           ir_q, ir_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  mem_err_q, mem_err_d;
    logic                  stall;

    logic d_valid, d_is_halt, d_is_mem, d_is_load, d_is_atomic, d_is_branch;
    logic d_is_bne, d_is_jump, d_is_link, d_writes_reg, d_alusrc;
    aluop_t            d_aluop;
    imm_sel_t          d_imm_sel;
    pc_select_t        d_jump_sel;
    wdatsel_t          d_wdatsel;
    logic [REG_AW-1:0] d_wsel;

    mc_decode #(.REG_AW(REG_AW)) u_decode (
        .ir(ir_q), .valid(d_valid), .is_halt(d_is_halt), .is_mem(d_is_mem),
        .is_load(d_is_load), .is_atomic(d_is_atomic), .is_branch(d_is_branch),
        .is_bne(d_is_bne), .is_jump(d_is_jump), .is_link(d_is_link),
        .writes_reg(d_writes_reg), .alusrc(d_alusrc), .aluop(d_aluop),
        .imm_sel(d_imm_sel), .jump_sel(d_jump_sel), .wdatsel(d_wdatsel), .wsel(d_wsel)
    );

    assign stall = (state_q == FETCH && !ihit) || (state_q == MEMORY && !dhit);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        case (state_q)
            FETCH: if (ihit) begin
                ir_d    = imemload[31:0];
                state_d = DECODE;
            end
            DECODE: begin
                if (d_is_halt)    state_d = HALTED;
                else if (!d_valid) state_d = FETCH;
                else              state_d = EXECUTE;
            end
            EXECUTE: begin
                if (d_is_mem)          state_d = MEMORY;
                else if (d_writes_reg) state_d = WRITEBACK;
                else                   state_d = FETCH;
            end
            MEMORY:    if (dhit) state_d = d_writes_reg ? WRITEBACK : FETCH;
            WRITEBACK: state_d = FETCH;
            HALTED:    state_d = HALTED;
            default:   state_d = FETCH;
        endcase
        // The count only advances while below WAIT_MAX, so it can never wrap
        if (stall) begin
            if ({1'b0, wait_cnt_q} + 17'd1 >= 17'(WAIT_MAX)) begin
                mem_err_d = 1'b1;
                state_d   = HALTED;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Requests are masked while nRST is low so nothing reaches the caches mid-reset.
    // ALU selects stay valid through MEMORY/WRITEBACK to hold the address and result steady.
    always_comb begin
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
        ir_en = 1'b0; pc_en = 1'b0; WEN = 1'b0;
        pc_select = NEXT; aluop = ALU_ADD; alusrc = 1'b0; imm_sel = SIGN;
        wdatsel = PORT_O; wsel = '0;
        if (nRST) begin
            if (state_q inside {EXECUTE, MEMORY, WRITEBACK}) begin
                aluop   = d_aluop;
                alusrc  = d_alusrc;
                imm_sel = d_imm_sel;
            end
            case (state_q)
                FETCH: begin
                    iREN  = 1'b1;
                    ir_en = ihit;
                    pc_en = ihit;
                end
                EXECUTE: begin
                    if (d_is_jump) begin
                        pc_en = 1'b1;
                        pc_select = d_jump_sel;
                    end
                    if (d_is_branch && (z_fl ^ d_is_bne)) begin
                        pc_en = 1'b1;
                        pc_select = BRANCH;
                    end
                    if (d_is_link) begin
                        WEN = 1'b1;
                        wsel = d_wsel;
                        wdatsel = d_wdatsel;
                    end
                end
                MEMORY: begin
                    dREN    = d_is_load;
                    dWEN    = !d_is_load;
                    datomic = d_is_atomic;
                end
                WRITEBACK: begin
                    WEN = 1'b1;
                    wsel = d_wsel;
                    wdatsel = d_wdatsel;
                end
                default: ;
            endcase
        end
    end

    assign cpu_halt = (state_q == HALTED);
    assign mem_err  = mem_err_q;

endmodule
